serial_word_loader: RTL
=======================

// Module: serial_word_loader
// PURPOSE
//   Serial-to-parallel front end for the 10-bit stage register (register_s0).
//   Collects a framed serial bit stream, MSB first, into a WIDTH-bit word.
//   Presents the word on dout and pulses en_out for one cycle.
//   dout/en_out wire directly to the stage register's din/en.
// PARAMETERS
//   WIDTH   10  word length in bits; must match the downstream register width
//   CNT_W    4  bit-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      single clock; all state updates on the rising edge
//   reset        in   1      asynchronous, active-low; 0 = reset
//   frame_start  in   1      sync pulse; starts (or restarts) a word
//   bit_in       in   1      serial data bit
//   bit_valid    in   1      bit_in is sampled at this edge when 1
//   dout         out  WIDTH  last completed word; connects to register din
//   en_out       out  1      one-cycle load strobe; connects to register en
//   busy         out  1      1 while state != IDLE
//   word_count   out  8      count of words delivered; wraps 255 -> 0
//   err_out      out  1      parity-error pulse (see CONFIGURATION)
// BEHAVIOUR
//   - Clock and reset: one clock; reset is asynchronous and active-low.
//   - Reset (reset=0, takes effect immediately, no clock edge needed):
//       state=IDLE; shift register and bit counter cleared; dout=0; en_out=0;
//       busy=0; word_count=0; err_out=0.
//   - All outputs are registered.
//   - FSM states: IDLE, SHIFT, LOAD (and PARITY when the macro is defined).
//   - IDLE:
//       frame_start=1 -> SHIFT; clear the bit counter and shift register.
//       bit_valid is ignored, including in the frame_start cycle.
//   - SHIFT:
//       Each edge with bit_valid=1 does: shreg <= {shreg[WIDTH-2:0], bit_in}; cnt++.
//       bit_valid=0 -> hold; gaps of any length are legal.
//       The edge accepting bit WIDTH-1 (the WIDTH-th bit) -> LOAD,
//       or -> PARITY when the macro is defined.
//   - SHIFT with frame_start=1 (any cnt, incl. the cycle with a bit):
//       Abort the partial word: cnt=0, shreg=0, stay in SHIFT.
//       The bit in that cycle is discarded.
//       frame_start has priority over bit_valid.
//   - LOAD (one cycle):
//       dout <= shreg at entry, so dout is valid in the same cycle en_out=1.
//       en_out=1 for exactly one cycle; word_count++ (8-bit wrap).
//       Next state is IDLE.
//       frame_start and bit_valid are ignored in LOAD.
//   - Latency:
//       en_out is high in the cycle after the edge that sampled the last data bit.
//       The downstream register captures dout on the following edge.
//       Minimum frame: 1 (frame_start) + WIDTH + 1 cycles.
//   - Between loads, dout holds its last value; en_out=0.
//   - Reset asserted mid-frame discards the partial word.
//     After reset release, a new frame_start is required.
// CONFIGURATION
//   Macro SERIAL_LOADER_PARITY_CHECK_EN:
//   - Defined:
//       After WIDTH data bits, SHIFT -> PARITY.
//       PARITY waits for one more bit_valid bit, the even-parity bit.
//       Check: ^{shreg,bit} == 0 -> LOAD as above.
//       Mismatch -> err_out=1 for one cycle; dout, word_count unchanged;
//       no en_out; -> IDLE.
//       frame_start in PARITY aborts -> SHIFT with cnt=0.
//   - Undefined: no PARITY state; err_out tied to 0; frame length is WIDTH bits.
// TESTING
//   1 reset=0 at t=0, mid-clock -> dout=0, en_out=0, busy=0, word_count=0
//     at once, without waiting for a clock edge.
//   2 frame_start; bits 0000011001 on consecutive cycles -> en_out high for
//     1 cycle after bit 10; dout=25; register dout=25 next edge; word_count=1.
//   3 frame_start; bits of 50 with bit_valid=0 gaps of 0..3 cycles
//     -> dout=50, exactly one en_out pulse; bits during gaps are ignored.
//   4 frame_start, 5 bits, then frame_start with bit_valid=1, then 10 bits of 100
//     -> a single en_out pulse; dout=100.
//   5 reset=0 after 6 bits of a frame -> busy=0 and dout keeps its reset value 0;
//     after release, bits without frame_start -> no en_out.
//   6 macro on: 75 + parity 0 -> dout=75, en_out pulse;
//     75 + parity 1 -> err_out pulse, no en_out, dout stays 75;
//     after 256 good words, word_count wraps to 0.

Source files
------------

// File: rtl/serial_word_loader.sv
// Serial MSB-first word collector feeding the stage register (din/en).
// Optional even-parity check: define SERIAL_LOADER_PARITY_CHECK_EN.
module serial_word_loader #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [WIDTH-1:0] dout,
   output logic             en_out,
   output logic             busy,
   output logic [7:0]       word_count,
   output logic             err_out
);

`ifdef SERIAL_LOADER_PARITY_CHECK_EN
   typedef enum logic [1:0] {
      S_IDLE, S_SHIFT, S_LOAD, S_PARITY
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_SHIFT, S_LOAD
   } state_t;
`endif

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_shreg, w_shreg_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [WIDTH-1:0] r_dout, w_dout_nx;
   logic             r_en, w_en_nx;
   logic             r_busy;
   logic [7:0]       r_wc, w_wc_nx;
   logic             r_err, w_err_nx;
   logic [WIDTH-1:0] w_shifted;
   logic             w_last;

   assign w_shifted = {r_shreg[WIDTH-2:0], bit_in};
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_nx = r_state;
      w_shreg_nx = r_shreg;
      w_cnt_nx   = r_cnt;
      w_dout_nx  = r_dout;
      w_en_nx    = 1'b0;
      w_wc_nx    = r_wc;
      w_err_nx   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_state_nx = S_SHIFT;
               w_shreg_nx = '0;
               w_cnt_nx   = '0;
            end
         end
         S_SHIFT: begin
            // frame_start wins: the bit arriving with it is dropped
            if (frame_start) begin
               w_shreg_nx = '0;
               w_cnt_nx   = '0;
            end else if (bit_valid) begin
               w_shreg_nx = w_shifted;
               w_cnt_nx   = r_cnt + CNT_W'(1);
               if (w_last) begin
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
                  w_state_nx = S_PARITY;
`else
                  w_state_nx = S_LOAD;
                  w_dout_nx  = w_shifted;
                  w_en_nx    = 1'b1;
                  w_wc_nx    = r_wc + 8'd1;
`endif
               end
            end
         end
`ifdef SERIAL_LOADER_PARITY_CHECK_EN
         S_PARITY: begin
            if (frame_start) begin
               w_state_nx = S_SHIFT;
               w_shreg_nx = '0;
               w_cnt_nx   = '0;
            end else if (bit_valid) begin
               if ((^{r_shreg, bit_in}) == 1'b0) begin
                  w_state_nx = S_LOAD;
                  w_dout_nx  = r_shreg;
                  w_en_nx    = 1'b1;
                  w_wc_nx    = r_wc + 8'd1;
               end else begin
                  w_state_nx = S_IDLE;
                  w_err_nx   = 1'b1;
               end
            end
         end
`endif
         S_LOAD: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // dout/en are loaded on LOAD entry so both are valid in the LOAD cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_wc    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_shreg <= w_shreg_nx;
         r_cnt   <= w_cnt_nx;
         r_dout  <= w_dout_nx;
         r_en    <= w_en_nx;
         r_busy  <= (w_state_nx != S_IDLE);
         r_wc    <= w_wc_nx;
         r_err   <= w_err_nx;
      end
   end

   assign dout       = r_dout;
   assign en_out     = r_en;
   assign busy       = r_busy;
   assign word_count = r_wc;
   assign err_out    = r_err;

endmodule
